// File: rtl/bit_serial_alu_seq.sv
// bit_serial_alu_seq: feeds a 1-bit ALU slice LSB first and assembles its result and final carry
module bit_serial_alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic [1:0]       slice_mode,
  output logic             slice_ain,
  output logic             slice_bin,
  output logic             slice_cin,
  input  logic [3:0]       slice_result,
  input  logic [3:0]       slice_cout
);
  localparam int IW = $clog2(WIDTH);
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
  state_t state, state_nxt;
  logic [WIDTH-1:0] opa, opb;
  logic [1:0] m, s;
  logic [IW-1:0] idx;
  logic carry, last, cout_sel;
  assign last = (state == S_SHIFT) && (idx == IW'(WIDTH - 1));
  assign cout_sel = (|m) & slice_cout[s];
  // state register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= S_IDLE;
    else state <= state_nxt;
  // next-state: accept in IDLE, shift WIDTH bits, one DONE cycle
  always_comb
    state_nxt = (state == S_IDLE) ? (start ? S_SHIFT : S_IDLE) :
                (state == S_SHIFT) ? (last ? S_DONE : S_SHIFT) : S_IDLE;
  // outputs: slice inputs are only driven while shifting
  always_comb begin
    busy = (state == S_SHIFT);
    done = (state == S_DONE);
    slice_mode = m;
    slice_ain = busy & opa[idx];
    slice_bin = busy & opb[idx];
    slice_cin = busy & carry;
  end
  // operand latch, bit index, running carry and result shifter
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      opa <= '0;
      opb <= '0;
      m <= '0;
      s <= '0;
      idx <= '0;
      carry <= 1'b0;
      result <= '0;
      carry_out <= 1'b0;
    end else if (state == S_IDLE && start) begin
      opa <= a;
      opb <= b;
      m <= (mode == 2'd3) ? 2'd2 : mode;
      s <= sel;
      idx <= '0;
      carry <= mode[1];
    end else if (busy) begin
      result <= {slice_result[s], result[WIDTH-1:1]};
      carry <= cout_sel;
      if (last) carry_out <= cout_sel;
      else idx <= idx + 1'b1;
    end
endmodule

// File: tb/tb_bit_serial_alu_seq.sv
// tb_bit_serial_alu_seq: directed vectors against a behavioural 1-bit slice model
module tb_bit_serial_alu_seq;
  logic clk = 0, reset_n, start;
  logic [1:0] mode, sel, slice_mode;
  logic [7:0] a, b, result;
  logic busy, done, carry_out, slice_ain, slice_bin, slice_cin;
  logic [3:0] slice_result, slice_cout;
  logic [1:0] t0, t1, t2, t3;
  logic [7:0] prev_res;
  logic prev_co;
  int errors = 0, checks = 0;

  bit_serial_alu_seq #(.WIDTH(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mode(mode), .sel(sel), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .carry_out(carry_out),
    .slice_mode(slice_mode), .slice_ain(slice_ain), .slice_bin(slice_bin), .slice_cin(slice_cin),
    .slice_result(slice_result), .slice_cout(slice_cout)
  );

  always #5 clk = ~clk;

  // slice model; cout forced high in mode 0 so a sequencer that uses it is caught
  always_comb begin
    t0 = 2'(slice_ain) + 2'(slice_cin);
    t1 = 2'(!slice_ain) + 2'(slice_cin);
    t2 = 2'(slice_ain) + 2'(slice_bin) + 2'(slice_cin);
    t3 = 2'(!slice_ain) + 2'(slice_bin) + 2'(slice_cin);
    if (slice_mode == 2'd0) begin
      slice_result = {~(slice_ain ^ slice_bin), slice_ain ^ slice_bin, ~slice_ain, slice_ain};
      slice_cout = 4'hF;
    end else begin
      slice_result = {t3[0], t2[0], t1[0], t0[0]};
      slice_cout = {t3[1], t2[1], t1[1], t0[1]};
    end
  end

  typedef struct {
    logic [1:0] mode, sel;
    logic [7:0] a, b, res;
    logic co;
  } vec_t;
  vec_t v[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_op(input logic [1:0] md, input logic [1:0] sl, input logic [7:0] aa,
                        input logic [7:0] bb, input logic [7:0] er, input logic ec, input string nm);
    int n;
    logic cin_hi;
    @(negedge clk);
    mode = md; sel = sl; a = aa; b = bb; start = 1;
    @(posedge clk); #1;
    start = 0; a = 8'($urandom); b = 8'($urandom); mode = 2'($urandom); sel = 2'($urandom);
    chk({nm, "_hold"}, {carry_out, result}, {prev_co, prev_res});
    chk({nm, "_busy"}, busy, 1);
    n = 0; cin_hi = 0;
    while (!done && n < 20) begin
      if (slice_cin) cin_hi = 1;
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_lat"}, n, 8);
    chk({nm, "_res"}, result, er);
    chk({nm, "_co"}, carry_out, ec);
    if (md == 2'd0) chk({nm, "_cin0"}, cin_hi, 0);
    @(posedge clk); #1;
    chk({nm, "_end"}, {busy, done}, 0);
    prev_res = er; prev_co = ec;
  endtask

  initial begin
    int pulses;
    v[0]  = '{2'd1, 2'd2, 8'hFF, 8'h01, 8'h00, 1'b1};
    v[1]  = '{2'd2, 2'd3, 8'h05, 8'h03, 8'hFE, 1'b0};
    v[2]  = '{2'd2, 2'd1, 8'h00, 8'h00, 8'h00, 1'b1};
    v[3]  = '{2'd3, 2'd1, 8'h00, 8'h00, 8'h00, 1'b1};
    v[4]  = '{2'd0, 2'd2, 8'hA5, 8'h0F, 8'hAA, 1'b0};
    v[5]  = '{2'd0, 2'd1, 8'h3C, 8'h00, 8'hC3, 1'b0};
    v[6]  = '{2'd0, 2'd3, 8'hA5, 8'h0F, 8'h55, 1'b0};
    v[7]  = '{2'd1, 2'd0, 8'h7F, 8'h00, 8'h7F, 1'b0};
    v[8]  = '{2'd2, 2'd0, 8'hFF, 8'h00, 8'h00, 1'b1};
    v[9]  = '{2'd1, 2'd3, 8'h05, 8'h03, 8'hFD, 1'b0};
    v[10] = '{2'd2, 2'd2, 8'h80, 8'h80, 8'h01, 1'b1};
    reset_n = 0; start = 0; mode = 0; sel = 0; a = 0; b = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctl", {busy, done, carry_out}, 0);
    chk("rst_res", result, 0);
    chk("rst_slice", {slice_mode, slice_ain, slice_bin, slice_cin}, 0);
    @(negedge clk); reset_n = 1;
    prev_res = 0; prev_co = 0;
    for (int i = 0; i < 11; i++)
      run_op(v[i].mode, v[i].sel, v[i].a, v[i].b, v[i].res, v[i].co, $sformatf("v%0d", i));
    // start pulses at edges 3 and 8 of an op are ignored
    @(negedge clk);
    mode = 1; sel = 2; a = 8'h12; b = 8'h34; start = 1;
    @(posedge clk); #1;
    start = 0; pulses = 0;
    for (int e = 1; e <= 12; e++) begin
      @(negedge clk);
      start = (e == 3 || e == 8); a = 8'hFF; b = 8'hFF;
      @(posedge clk); #1;
      if (done) pulses++;
    end
    start = 0;
    chk("ign_pulses", pulses, 1);
    chk("ign_res", result, 8'h46);
    chk("ign_co", carry_out, 0);
    chk("ign_idle", {busy, done}, 0);
    prev_res = 8'h46; prev_co = 0;
    // reset in the middle of an operation
    @(negedge clk);
    mode = 2; sel = 2; a = 8'h80; b = 8'h80; start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (3) @(posedge clk);
    @(negedge clk); reset_n = 0; #1;
    chk("mid_ctl", {busy, done, carry_out}, 0);
    chk("mid_res", result, 0);
    chk("mid_slice", {slice_mode, slice_ain, slice_bin, slice_cin}, 0);
    @(posedge clk); #1;
    chk("mid_nodone", done, 0);
    @(negedge clk); reset_n = 1;
    prev_res = 0; prev_co = 0;
    run_op(2'd1, 2'd2, 8'hFF, 8'h01, 8'h00, 1'b1, "post_rst");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
